// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter_pkg: shared types for the unified memory-port arbiter
package cpu_mem_arbiter_pkg;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [1:0] {IDLE, INST, DATA} lc3b_arb_state;
  typedef enum logic {ARB_INST, ARB_DATA} lc3b_arb_side;
endpackage

// File: rtl/cpu_mem_arbiter_resp_buf.sv
// arb_resp_buf: held completion flag and data buffer for one side; set beats clear
module arb_resp_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         done,
  output logic [W-1:0] dout
);
  // flag holds until consumed; data only replaced by loads, not stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      dout <= '0;
    end else begin
      done <= set | (done & ~clr);
      if (set & load) dout <= din;
    end
  end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serialises inst/data ports onto one memory port; ARB_RR_EN selects round-robin
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    advance,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  output logic                    inst_resp,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_be,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);
  lc3b_arb_state state, state_n;
  logic inst_done, data_done, inst_pend, data_pend, pick_data;
  logic grant, grant_data, fin;
  assign inst_pend = inst_req & ~inst_done;
  assign data_pend = data_req & ~data_done;
`ifdef ARB_RR_EN
  lc3b_arb_side last_g;
  assign pick_data = data_pend & (~inst_pend | (last_g == ARB_INST));
  // remember the most recently granted side, including chained grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_g <= ARB_DATA;
    else if (grant) last_g <= grant_data ? ARB_DATA : ARB_INST;
  end
`else
  assign pick_data = data_pend;
`endif
  // grant decision and next state; a completing side hands off directly to a pending peer
  always_comb begin
    fin        = (state != IDLE) & mem_resp;
    grant      = ((state == IDLE) & (inst_pend | data_pend)) |
                 ((state == INST) & mem_resp & data_pend) |
                 ((state == DATA) & mem_resp & inst_pend);
    grant_data = (state == IDLE) ? pick_data : (state == INST);
    state_n    = grant ? (grant_data ? DATA : INST) : fin ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // memory port registers: captured on grant, frozen until completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant) begin
      mem_read  <= ~(grant_data & data_we);
      mem_write <= grant_data & data_we;
      mem_addr  <= grant_data ? data_addr : inst_addr;
      mem_wdata <= grant_data ? data_wdata : '0;
      mem_be    <= grant_data ? data_be : '1;
    end else if (fin) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end
  arb_resp_buf #(.W(DATA_WIDTH)) u_inst_buf (
    .clk(clk), .rst_n(rst_n),
    .set((state == INST) & mem_resp), .load(1'b1), .clr(advance | ~inst_req),
    .din(mem_rdata), .done(inst_done), .dout(inst_rdata)
  );
  arb_resp_buf #(.W(DATA_WIDTH)) u_data_buf (
    .clk(clk), .rst_n(rst_n),
    .set((state == DATA) & mem_resp), .load(~mem_write), .clr(advance | ~data_req),
    .din(mem_rdata), .done(data_done), .dout(data_rdata)
  );
  assign inst_resp = inst_done;
  assign data_resp = data_done;
endmodule
